// File: rtl/spi_se_cmd_if.sv
// Command/status and SPI pin bundle for the sector-erase sequencer.
// The slave side is the sequencer and the master side is whoever drives it.
interface spi_se_cmd_if;
  logic        se_start;
  logic        addr_clr;
  logic        se_end;
  logic        busy;
  logic [23:0] sector_addr;
  logic        cs_n;
  logic        sck;
  logic        mosi;

  modport slave (
    input  se_start, addr_clr,
    output se_end, busy, sector_addr, cs_n, sck, mosi
  );

  modport master (
    output se_start, addr_clr,
    input  se_end, busy, sector_addr, cs_n, sck, mosi
  );
endinterface

// File: rtl/spi_se_cmd.sv
// Issues WREN (06h), then after a cs_n-high gap SE (D8h + 24-bit address), to a SPI flash.
// The address auto-advances by STEP after each completed erase.
module spi_se_cmd #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned GAP       = 8,
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [23:0] STEP      = 24'h010000
) (
  input logic         sclk,
  input logic         rst_n,
  spi_se_cmd_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StWren, StGap, StSe, StDone} state_e;

  localparam logic [15:0] PhLast  = 16'(DIV - 1);
  localparam logic [15:0] PhHigh  = 16'(DIV / 2);
  localparam logic [15:0] GapLast = 16'(GAP - 1);

  state_e      state_q;
  logic [15:0] ph_q;
  logic [15:0] gap_q;
  logic [4:0]  bit_q;
  logic [31:0] sh_q;
  logic        cs_n_q;
  logic        sck_q;
  logic        se_end_q;
  logic        busy_q;
  logic [23:0] addr_q;

  logic [15:0] ph_inc;
  logic        frame_last;

  assign ph_inc     = ph_q + 16'd1;
  assign frame_last = (state_q == StWren) ? (bit_q == 5'd7) : (bit_q == 5'd31);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ph_q     <= '0;
      gap_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      se_end_q <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= BASE_ADDR;
    end else begin
      se_end_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.se_start) begin
            state_q <= StWren;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            sck_q   <= 1'b0;
            ph_q    <= '0;
            bit_q   <= '0;
            sh_q    <= {8'h06, 24'h000000};
          end
        end
        StWren, StSe: begin
          if (ph_q == PhLast) begin
            ph_q  <= '0;
            sck_q <= 1'b0;
            if (frame_last) begin
              // Clearing the shifter parks mosi low while cs_n is high.
              cs_n_q <= 1'b1;
              sh_q   <= '0;
              gap_q  <= '0;
              if (state_q == StWren) begin
                state_q <= StGap;
              end else begin
                state_q  <= StDone;
                se_end_q <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 5'd1;
              sh_q  <= {sh_q[30:0], 1'b0};
            end
          end else begin
            ph_q  <= ph_inc;
            sck_q <= (ph_inc >= PhHigh);
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_q <= StSe;
            cs_n_q  <= 1'b0;
            ph_q    <= '0;
            bit_q   <= '0;
            sh_q    <= {8'hD8, addr_q};
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          addr_q  <= addr_q + STEP;
        end
        default: state_q <= StIdle;
      endcase
      // Placed last so a clear overrides the post-erase increment.
      if (bus.addr_clr) addr_q <= BASE_ADDR;
    end
  end

  assign bus.cs_n        = cs_n_q;
  assign bus.sck         = sck_q;
  assign bus.mosi        = sh_q[31];
  assign bus.se_end      = se_end_q;
  assign bus.busy        = busy_q;
  assign bus.sector_addr = addr_q;

endmodule

// File: tb/tb_spi_se_cmd.sv
// Bench for spi_se_cmd: per-cycle timeline model of each erase plus decoded SPI bytes,
// on a default instance and a DIV=2/GAP=1/BASE=FF0000 instance.
module tb_spi_se_cmd;

  localparam int          Div0  = 4;
  localparam int          Gap0  = 8;
  localparam logic [23:0] Base0 = 24'h000000;
  localparam int          Div1  = 2;
  localparam int          Gap1  = 1;
  localparam logic [23:0] Base1 = 24'hFF0000;
  localparam logic [23:0] Step  = 24'h010000;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;

  spi_se_cmd_if bus0 ();
  spi_se_cmd_if bus1 ();

  spi_se_cmd u_dut0 (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  spi_se_cmd #(
    .DIV       (Div1),
    .GAP       (Gap1),
    .BASE_ADDR (Base1),
    .STEP      (Step)
  ) u_dut1 (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 sclk = ~sclk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          se_end_seen0 = 0;
  int          se_end_exp0  = 0;
  logic [23:0] exp_addr [2];

  always @(posedge sclk) if (bus0.se_end) se_end_seen0++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample(input int sel, output logic cs, output logic sk, output logic mo,
                        output logic se, output logic bz, output logic [23:0] ad);
    if (sel == 0) begin
      cs = bus0.cs_n; sk = bus0.sck; mo = bus0.mosi;
      se = bus0.se_end; bz = bus0.busy; ad = bus0.sector_addr;
    end else begin
      cs = bus1.cs_n; sk = bus1.sck; mo = bus1.mosi;
      se = bus1.se_end; bz = bus1.busy; ad = bus1.sector_addr;
    end
  endtask

  task automatic drive(input int sel, input logic start, input logic clr);
    if (sel == 0) begin
      bus0.se_start = start; bus0.addr_clr = clr;
    end else begin
      bus1.se_start = start; bus1.addr_clr = clr;
    end
  endtask

  // Outputs expected while idle or held in reset.
  task automatic check_quiet(input int sel, input logic [23:0] addr);
    logic cs, sk, mo, se, bz;
    logic [23:0] ad;
    sample(sel, cs, sk, mo, se, bz, ad);
    check("quiet_cs_n", cs, 1'b1);
    check("quiet_sck", sk, 1'b0);
    check("quiet_mosi", mo, 1'b0);
    check("quiet_se_end", se, 1'b0);
    check("quiet_busy", bz, 1'b0);
    check("quiet_addr", ad, addr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      check_quiet(0, exp_addr[0]);
      check_quiet(1, exp_addr[1]);
      @(negedge sclk);
    end
  endtask

  // One erase on instance sel. Called just after a negedge. clr_at/abort_at/noise_* are
  // cycle offsets after the accepting edge (-1 = unused).
  task automatic run_erase(input int sel, input int clr_at, input int abort_at,
                           input int noise_a, input int noise_b);
    int div, gw, w, g, s, d, idx;
    logic cs, sk, mo, se, bz, prev_sk;
    logic e_cs, e_sk, e_mo, e_se, e_bz;
    logic [23:0] ad, base;
    logic [7:0]  wren_byte;
    logic [31:0] se_word;
    logic [39:0] rx;
    div       = (sel == 0) ? Div0 : Div1;
    gw        = (sel == 0) ? Gap0 : Gap1;
    base      = (sel == 0) ? Base0 : Base1;
    w         = 8 * div;
    g         = gw;
    s         = 32 * div;
    d         = w + g + s + 1;
    wren_byte = 8'h06;
    se_word   = '0;
    rx        = '0;
    prev_sk   = 1'b0;
    drive(sel, 1'b1, 1'b0);
    @(negedge sclk);
    drive(sel, 1'b0, 1'b0);
    for (int k = 1; k <= d + 1; k++) begin
      sample(sel, cs, sk, mo, se, bz, ad);
      e_cs = 1'b1; e_sk = 1'b0; e_mo = 1'b0; e_se = 1'b0; e_bz = 1'b1;
      if (k <= w) begin
        idx  = k - 1;
        e_cs = 1'b0;
        e_sk = ((idx % div) >= (div / 2));
        e_mo = wren_byte[7 - idx / div];
      end else if (k <= w + g) begin
        e_cs = 1'b1;
      end else if (k <= w + g + s) begin
        idx  = k - w - g - 1;
        e_cs = 1'b0;
        e_sk = ((idx % div) >= (div / 2));
        e_mo = se_word[31 - idx / div];
      end else if (k == d) begin
        e_se = 1'b1;
      end else begin
        e_bz = 1'b0;
      end
      check("cs_n", cs, e_cs);
      check("sck", sk, e_sk);
      check("mosi", mo, e_mo);
      check("se_end", se, e_se);
      check("busy", bz, e_bz);
      check("sector_addr", ad, exp_addr[sel]);
      if (!cs && sk && !prev_sk) rx = {rx[38:0], mo};
      prev_sk = sk;
      if (k == d) check("decoded_bytes", rx, {8'h06, se_word});
      // The SE frame carries the address held just before the edge that opens it.
      if (k == w + g) se_word = {8'hD8, exp_addr[sel]};
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        exp_addr[0] = Base0;
        exp_addr[1] = Base1;
        check_quiet(sel, base);
        for (int i = 0; i < 4; i++) begin
          @(negedge sclk);
          check_quiet(0, Base0);
          check_quiet(1, Base1);
        end
        rst_n = 1'b1;
        return;
      end
      drive(sel, (k == noise_a) || (k == noise_b), k == clr_at);
      if (k == clr_at) exp_addr[sel] = base;
      else if (k == d) exp_addr[sel] = exp_addr[sel] + Step;
      if (k == d && sel == 0) se_end_exp0++;
      @(negedge sclk);
      drive(sel, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int clr_pos, na, nb;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    exp_addr[0] = Base0;
    exp_addr[1] = Base1;
    rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    check_quiet(0, Base0);
    check_quiet(1, Base1);
    rst_n = 1'b1;

    // Start on the very first edge after reset release; 06 / D8 000000, addr -> 010000.
    run_erase(0, -1, -1, -1, -1);
    check("single_next_addr", bus0.sector_addr, 24'h010000);

    drive(0, 1'b0, 1'b1);
    @(negedge sclk);
    drive(0, 1'b0, 1'b0);
    exp_addr[0] = Base0;

    for (int i = 0; i < 8; i++) begin
      idle(9);
      run_erase(0, -1, -1, -1, -1);
    end
    check("eight_erases_addr", bus0.sector_addr, 24'h080000);

    // Requests during an active erase are dropped.
    idle(10);
    run_erase(0, -1, -1, 5, 100);
    idle(200);

    drive(0, 1'b0, 1'b1);
    @(negedge sclk);
    drive(0, 1'b0, 1'b0);
    exp_addr[0] = Base0;
    for (int i = 0; i < 3; i++) begin
      idle(3);
      run_erase(0, -1, -1, -1, -1);
    end
    check("addr_before_clr", bus0.sector_addr, 24'h030000);
    idle(3);
    run_erase(0, 169, -1, -1, -1);
    check("clr_beats_increment", bus0.sector_addr, 24'h000000);

    // Clear mid-SE must not disturb the frame in flight.
    idle(3);
    run_erase(0, -1, -1, -1, -1);
    idle(3);
    run_erase(0, 60, -1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      clr_pos = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 169));
      na      = int'($urandom_range(2, 168));
      nb      = int'($urandom_range(2, 168));
      idle(int'($urandom_range(1, 20)));
      run_erase(0, clr_pos, -1, na, nb);
    end

    // Small-divider instance: FF0000 then wrap to 000000.
    idle(4);
    run_erase(1, -1, -1, -1, -1);
    check("wrap_addr", bus1.sector_addr, 24'h000000);
    idle(4);
    run_erase(1, -1, -1, 7, -1);

    // Reset mid-SE, then restart on the first edge after release.
    idle(5);
    run_erase(0, -1, 60, -1, -1);
    run_erase(0, -1, -1, -1, -1);
    idle(5);

    check("se_end_count", se_end_seen0, se_end_exp0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
